// File: rtl/systolic_kv_priority_queue_pkg.sv
// Shared types and the key comparison used by the systolic key/value priority queue.
package pq_pkg;

  typedef enum logic [1:0] {
    PQ_NOP,
    PQ_ENQ,
    PQ_DEQ,
    PQ_REPL
  } pq_op_e;

  typedef enum logic {
    PH_IDLE,
    PH_SETTLE
  } pq_phase_e;

  localparam int PQ_CMP_W = 64;

  // Keys are zero-extended to PQ_CMP_W bits so one function serves every KEY_WIDTH.
  function automatic logic pq_better(input logic [PQ_CMP_W-1:0] a,
                                     input logic [PQ_CMP_W-1:0] b,
                                     input logic                max_mode);
    return max_mode ? (a > b) : (a < b);
  endfunction

endpackage

// File: rtl/systolic_kv_priority_queue_if.sv
// Request/status bundle of the systolic key/value priority queue.
// PQ_ERR_FLAGS_EN adds the sticky o_ovf/o_udf status lines.
interface systolic_kv_priority_queue_if #(
  parameter int QUEUE_SIZE = 16,
  parameter int KEY_WIDTH  = 16,
  parameter int VAL_WIDTH  = 16
);
  localparam int CW = $clog2(QUEUE_SIZE + 1);

  logic                 i_enq;
  logic                 i_deq;
  logic [KEY_WIDTH-1:0] i_key;
  logic [VAL_WIDTH-1:0] i_val;
  logic                 o_ready;
  logic                 o_full;
  logic                 o_empty;
  logic [KEY_WIDTH-1:0] o_key;
  logic [VAL_WIDTH-1:0] o_val;
  logic [CW-1:0]        o_count;
`ifdef PQ_ERR_FLAGS_EN
  logic                 o_ovf;
  logic                 o_udf;
`endif

  modport slave (
    input  i_enq, i_deq, i_key, i_val,
    output o_ready, o_full, o_empty, o_key, o_val, o_count
`ifdef PQ_ERR_FLAGS_EN
    , output o_ovf, o_udf
`endif
  );

  modport master (
    output i_enq, i_deq, i_key, i_val,
    input  o_ready, o_full, o_empty, o_key, o_val, o_count
`ifdef PQ_ERR_FLAGS_EN
    , input o_ovf, o_udf
`endif
  );

endinterface

// File: rtl/systolic_kv_priority_queue_pair_cell.sv
// One systolic node of two slots; the slot array stays sorted best-first, and each slot
// settles from its own entry, its neighbours' entries and their "new key is better" flags.
module pq_pair_cell
  import pq_pkg::*;
#(
  parameter int KEY_WIDTH = 16,
  parameter int VAL_WIDTH = 16,
  parameter int MAX_MODE  = 0,
  parameter int IS_HEAD   = 0
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         i_settle,
  input  pq_op_e                       i_op,
  input  logic [KEY_WIDTH+VAL_WIDTH:0] i_new,
  input  logic [KEY_WIDTH+VAL_WIDTH:0] i_left,
  input  logic                         i_left_lt,
  input  logic [KEY_WIDTH+VAL_WIDTH:0] i_right,
  input  logic                         i_right_lt,
  output logic [KEY_WIDTH+VAL_WIDTH:0] o_e0,
  output logic [KEY_WIDTH+VAL_WIDTH:0] o_e1,
  output logic                         o_lt0,
  output logic                         o_lt1
);

  typedef struct packed {
    logic                 valid;
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } entry_t;

  entry_t w_new;
  entry_t w_s [0:3];
  logic   w_l [0:3];

  assign w_new  = entry_t'(i_new);
  assign w_s[0] = entry_t'(i_left);
  assign w_s[3] = entry_t'(i_right);
  assign w_l[0] = i_left_lt;
  assign w_l[3] = i_right_lt;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_slot
    entry_t r_e;
    entry_t w_e_next;
    logic   w_keep_ok;

    assign w_s[gi+1] = r_e;
    // Empty slots sit at the tail and count as worse than any key.
    assign w_l[gi+1] = !r_e.valid ||
                       pq_better(PQ_CMP_W'(w_new.key), PQ_CMP_W'(r_e.key), MAX_MODE != 0);
    // On replace the head slot never keeps its entry: that entry is the one removed.
    assign w_keep_ok = !((IS_HEAD != 0) && (gi == 0));

    always_comb begin
      w_e_next = r_e;
      case (i_op)
        PQ_ENQ:  w_e_next = w_l[gi] ? w_s[gi] : (w_l[gi+1] ? w_new : r_e);
        PQ_DEQ:  w_e_next = w_s[gi+2];
        PQ_REPL: w_e_next = (w_keep_ok && w_l[gi+1]) ? r_e :
                            (w_l[gi+2] ? w_new : w_s[gi+2]);
        default: ;
      endcase
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        r_e <= '0;
      end else if (i_settle) begin
        r_e <= w_e_next;
      end
    end
  end

  assign o_e0  = w_s[1];
  assign o_e1  = w_s[2];
  assign o_lt0 = w_l[1];
  assign o_lt1 = w_l[2];

endmodule

// File: rtl/systolic_kv_priority_queue.sv
// Systolic key/value priority queue: op capture at the head, one parallel settle cycle.
// Optional macro PQ_ERR_FLAGS_EN adds sticky overflow/underflow flags.
module systolic_kv_priority_queue
  import pq_pkg::*;
#(
  parameter int QUEUE_SIZE = 16,
  parameter int KEY_WIDTH  = 16,
  parameter int VAL_WIDTH  = 16,
  parameter int MAX_MODE   = 0
) (
  input  logic                           CLK,
  input  logic                           RST,
  systolic_kv_priority_queue_if.slave    bus
);

  localparam int CW     = $clog2(QUEUE_SIZE + 1);
  localparam int EW     = 1 + KEY_WIDTH + VAL_WIDTH;
  localparam int NPAIRS = QUEUE_SIZE / 2;

  typedef struct packed {
    logic                 valid;
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } entry_t;

  pq_phase_e     r_phase;
  pq_phase_e     w_phase_next;
  pq_op_e        r_op;
  pq_op_e        w_req_op;
  entry_t        r_in;
  logic [CW-1:0] r_count;
  logic          w_ready;
  logic          w_accept;
  logic          w_settle;
  logic          w_full;
  logic          w_empty;
  entry_t        w_head;

  // Slot j lives at index j+1; indices 0 and QUEUE_SIZE+1 are the virtual ends.
  logic [EW-1:0] w_ext    [0:QUEUE_SIZE+1];
  logic          w_lt_ext [0:QUEUE_SIZE+1];

  assign w_ext[0]               = '0;
  assign w_ext[QUEUE_SIZE+1]    = '0;
  assign w_lt_ext[0]            = 1'b0;
  assign w_lt_ext[QUEUE_SIZE+1] = 1'b1;

  assign w_ready  = (r_phase == PH_IDLE);
  assign w_accept = w_ready && (bus.i_enq || bus.i_deq);
  assign w_full   = (r_count == CW'(QUEUE_SIZE));
  assign w_empty  = (r_count == '0);

  // Dropped enq-on-full and deq-on-empty collapse to NOP; replace on empty is a plain enq.
  always_comb begin
    w_req_op = PQ_NOP;
    case ({bus.i_enq, bus.i_deq})
      2'b10:   if (!w_full)  w_req_op = PQ_ENQ;
      2'b01:   if (!w_empty) w_req_op = PQ_DEQ;
      2'b11:   w_req_op = w_empty ? PQ_ENQ : PQ_REPL;
      default: ;
    endcase
  end

  always_comb begin
    w_phase_next = r_phase;
    w_settle     = 1'b0;
    case (r_phase)
      PH_IDLE:   if (w_accept) w_phase_next = PH_SETTLE;
      PH_SETTLE: begin
        w_settle     = 1'b1;
        w_phase_next = PH_IDLE;
      end
      default:   w_phase_next = PH_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_phase <= PH_IDLE;
      r_op    <= PQ_NOP;
      r_in    <= '0;
      r_count <= '0;
    end else begin
      r_phase <= w_phase_next;
      if (w_accept) begin
        r_op <= w_req_op;
        r_in <= '{valid: 1'b1, key: bus.i_key, val: bus.i_val};
      end
      if (w_settle) begin
        case (r_op)
          PQ_ENQ:  r_count <= r_count + CW'(1);
          PQ_DEQ:  r_count <= r_count - CW'(1);
          default: ;
        endcase
      end
    end
  end

  genvar gi;
  for (gi = 0; gi < NPAIRS; gi++) begin : g_pair
    pq_pair_cell #(
      .KEY_WIDTH (KEY_WIDTH),
      .VAL_WIDTH (VAL_WIDTH),
      .MAX_MODE  (MAX_MODE),
      .IS_HEAD   ((gi == 0) ? 1 : 0)
    ) u_cell (
      .CLK        (CLK),
      .RST        (RST),
      .i_settle   (w_settle),
      .i_op       (r_op),
      .i_new      (r_in),
      .i_left     (w_ext[2*gi]),
      .i_left_lt  (w_lt_ext[2*gi]),
      .i_right    (w_ext[2*gi+3]),
      .i_right_lt (w_lt_ext[2*gi+3]),
      .o_e0       (w_ext[2*gi+1]),
      .o_e1       (w_ext[2*gi+2]),
      .o_lt0      (w_lt_ext[2*gi+1]),
      .o_lt1      (w_lt_ext[2*gi+2])
    );
  end

  assign w_head      = entry_t'(w_ext[1]);
  assign bus.o_ready = w_ready;
  assign bus.o_full  = w_full;
  assign bus.o_empty = w_empty;
  assign bus.o_count = r_count;
  assign bus.o_key   = w_head.valid ? w_head.key : '0;
  assign bus.o_val   = w_head.valid ? w_head.val : '0;

`ifdef PQ_ERR_FLAGS_EN
  logic r_ovf;
  logic r_udf;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (w_accept) begin
      if (bus.i_enq && !bus.i_deq && w_full)  r_ovf <= 1'b1;
      if (bus.i_deq && !bus.i_enq && w_empty) r_udf <= 1'b1;
    end
  end

  assign bus.o_ovf = r_ovf;
  assign bus.o_udf = r_udf;
`endif

endmodule

// File: tb/tb_systolic_kv_priority_queue.sv
// Scoreboard bench: min-mode and max-mode queues driven in lockstep against a reference
// multiset model; the monitor checks each completed op when o_ready comes back.
module tb_systolic_kv_priority_queue;

  localparam int QS = 16;
  localparam int KW = 16;
  localparam int VW = 16;

  typedef struct {
    int unsigned key;
    int unsigned val;
    int unsigned count;
    bit          ovf;
    bit          udf;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  systolic_kv_priority_queue_if #(.QUEUE_SIZE(QS), .KEY_WIDTH(KW), .VAL_WIDTH(VW)) bus_min ();
  systolic_kv_priority_queue_if #(.QUEUE_SIZE(QS), .KEY_WIDTH(KW), .VAL_WIDTH(VW)) bus_max ();

  systolic_kv_priority_queue #(.QUEUE_SIZE(QS), .KEY_WIDTH(KW), .VAL_WIDTH(VW), .MAX_MODE(0))
    dut_min (.CLK(CLK), .RST(RST), .bus(bus_min.slave));
  systolic_kv_priority_queue #(.QUEUE_SIZE(QS), .KEY_WIDTH(KW), .VAL_WIDTH(VW), .MAX_MODE(1))
    dut_max (.CLK(CLK), .RST(RST), .bus(bus_max.slave));

  int unsigned model [2][$];
  exp_t        exp_q [2][$];
  bit          m_ovf;
  bit          m_udf;
  bit          chk_req;
  int          tests;
  int          fails;
  int          txn;

  // Payload is a bijection of the key, so ties between equal keys never make it ambiguous.
  function automatic int unsigned vfun(input int unsigned k);
    return (k * 32'd40503 + 32'd4660) & 32'h0000_FFFF;
  endfunction

  function automatic int best_idx(input int m);
    int bi;
    bi = -1;
    for (int i = 0; i < model[m].size(); i++) begin
      if (bi < 0) bi = i;
      else if (m == 0 && model[m][i] < model[m][bi]) bi = i;
      else if (m == 1 && model[m][i] > model[m][bi]) bi = i;
    end
    return bi;
  endfunction

  task automatic push_exp();
    for (int m = 0; m < 2; m++) begin
      exp_t e;
      int   bi;
      bi      = best_idx(m);
      e.key   = (bi < 0) ? 0 : model[m][bi];
      e.val   = (bi < 0) ? 0 : vfun(e.key);
      e.count = model[m].size();
      e.ovf   = m_ovf;
      e.udf   = m_udf;
      exp_q[m].push_back(e);
    end
  endtask

  task automatic model_step(input bit enq, input bit deq, input int unsigned key);
    for (int m = 0; m < 2; m++) begin
      int bi;
      bi = best_idx(m);
      if (enq && !deq) begin
        if (model[m].size() < QS) model[m].push_back(key);
        else m_ovf = 1'b1;
      end else if (deq && !enq) begin
        if (bi >= 0) model[m].delete(bi);
        else m_udf = 1'b1;
      end else if (enq && deq) begin
        if (bi >= 0) model[m].delete(bi);
        model[m].push_back(key);
      end
    end
    push_exp();
  endtask

  task automatic set_in(input bit e, input bit d, input int unsigned k);
    bus_min.i_enq = e;
    bus_max.i_enq = e;
    bus_min.i_deq = d;
    bus_max.i_deq = d;
    bus_min.i_key = 16'(k);
    bus_max.i_key = 16'(k);
    bus_min.i_val = 16'(vfun(k));
    bus_max.i_val = 16'(vfun(k));
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge CLK);
    while (!bus_min.o_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!bus_min.o_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout got=0 exp=1");
    end
  endtask

  task automatic do_op(input bit e, input bit d, input int unsigned k);
    wait_ready();
    set_in(e, d, k);
    model_step(e, d, k);
    @(posedge CLK);
    #1 set_in(1'b0, 1'b0, 0);
  endtask

  task automatic check(input string nm, input int m, input int unsigned got, input int unsigned exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s inst=%s got=%0d exp=%0d", nm, (m == 0) ? "min" : "max", got, exp);
    end
  endtask

  // Monitor: one completed transaction per o_ready rise (or an explicit idle check).
  initial begin
    bit prev_ready;
    bit rise;
    prev_ready = 1'b1;
    forever begin
      @(negedge CLK);
      rise       = !prev_ready && bus_min.o_ready;
      prev_ready = bus_min.o_ready;
      if (rise || chk_req) begin
        txn++;
        $display("[TB] txn %0d min_head=%0d max_head=%0d count=%0d",
                 txn, bus_min.o_key, bus_max.o_key, bus_min.o_count);
        for (int m = 0; m < 2; m++) begin
          exp_t        e;
          int unsigned gk, gv, gc, ge, gf, go, gu;
          gk = (m == 0) ? bus_min.o_key   : bus_max.o_key;
          gv = (m == 0) ? bus_min.o_val   : bus_max.o_val;
          gc = (m == 0) ? bus_min.o_count : bus_max.o_count;
          ge = (m == 0) ? bus_min.o_empty : bus_max.o_empty;
          gf = (m == 0) ? bus_min.o_full  : bus_max.o_full;
          go = 0;
          gu = 0;
`ifdef PQ_ERR_FLAGS_EN
          go = (m == 0) ? bus_min.o_ovf : bus_max.o_ovf;
          gu = (m == 0) ? bus_min.o_udf : bus_max.o_udf;
`endif
          if (exp_q[m].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output inst=%0d got_key=%0d exp=none", m, gk);
          end else begin
            e = exp_q[m].pop_front();
            check("head_key", m, gk, e.key);
            check("head_val", m, gv, e.val);
            check("count", m, gc, e.count);
            check("empty", m, ge, (e.count == 0) ? 1 : 0);
            check("full", m, gf, (e.count == QS) ? 1 : 0);
`ifdef PQ_ERR_FLAGS_EN
            check("ovf", m, go, e.ovf ? 1 : 0);
            check("udf", m, gu, e.udf ? 1 : 0);
`else
            if (go != 0 || gu != 0) begin
              tests++;
              fails++;
              $display("FAIL flags_absent got=%0d exp=0", go + gu);
            end
`endif
          end
        end
      end
    end
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int unsigned fill_keys [16];
    int unsigned small_keys [5];
    int unsigned edge_keys [4];
    int unsigned mx_keys [3];
    tests   = 0;
    fails   = 0;
    txn     = 0;
    chk_req = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    fill_keys  = '{40, 7, 300, 7, 12, 999, 1, 55, 0, 65535, 128, 7, 2, 1000, 33, 500};
    small_keys = '{10, 20, 30, 40, 50};
    edge_keys  = '{0, 1, 65534, 65535};
    mx_keys    = '{3, 9, 6};
    set_in(1'b0, 1'b0, 0);

    // Reset, idle, then check the reset state.
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    push_exp();
    chk_req = 1'b1;
    @(posedge CLK);
    #1 chk_req = 1'b0;

    // Fill to capacity, overflow attempt, drain, underflow attempt.
    foreach (fill_keys[i]) do_op(1'b1, 1'b0, fill_keys[i]);
    do_op(1'b1, 1'b0, 3);
    repeat (QS) do_op(1'b0, 1'b1, 0);
    do_op(1'b0, 1'b1, 0);

    // Replace sequences at count 5.
    foreach (small_keys[i]) do_op(1'b1, 1'b0, small_keys[i]);
    do_op(1'b1, 1'b1, 5);
    do_op(1'b1, 1'b1, 60);

    // A request held into the settle cycle must be ignored.
    wait_ready();
    set_in(1'b1, 1'b0, 25);
    model_step(1'b1, 1'b0, 25);
    @(posedge CLK);
    #1 set_in(1'b1, 1'b0, 0);
    @(posedge CLK);
    #1 set_in(1'b0, 1'b0, 0);

    // Reset landing on the settle edge empties the queue.
    wait_ready();
    set_in(1'b1, 1'b0, 4242);
    model[0].delete();
    model[1].delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    push_exp();
    @(posedge CLK);
    #1 set_in(1'b0, 1'b0, 0);
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;

    // Replace on empty, then the min/max head comparison.
    do_op(1'b1, 1'b1, 77);
    do_op(1'b0, 1'b1, 0);
    foreach (mx_keys[i]) do_op(1'b1, 1'b0, mx_keys[i]);
    do_op(1'b0, 1'b1, 0);

    // Randomised traffic: fill-heavy first half, drain-heavy second half.
    for (int i = 0; i < 320; i++) begin
      int unsigned r, sel, k, enq_thr;
      r       = $urandom_range(0, 9);
      sel     = $urandom_range(0, 3);
      enq_thr = (i < 160) ? 6 : 2;
      if (sel == 0)      k = edge_keys[$urandom_range(0, 3)];
      else if (sel == 1) k = $urandom_range(0, 15);
      else               k = $urandom_range(0, 65535);
      if (r < enq_thr)   do_op(1'b1, 1'b0, k);
      else if (r < 8)    do_op(1'b0, 1'b1, 0);
      else if (r < 9)    do_op(1'b1, 1'b1, k);
      else               @(posedge CLK);
    end

    repeat (4) @(negedge CLK);
    check("leftover_expect", 0, exp_q[0].size(), 0);
    check("leftover_expect", 1, exp_q[1].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
